// File: rtl/axi_mm_pkg.sv
// ----------------------------------------------------------------------------
// axi_mm_pkg : shared AXI codes and FSM encodings for the axi_mm slave front end
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package axi_mm_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/axi_mm_burst_addr.sv
// ----------------------------------------------------------------------------
// axi_mm_burst_addr : per-direction word-address / beat counter for AXI bursts
// Revision          : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axi_mm_burst_addr
  import axi_mm_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_len,
  input  logic [1:0]           load_burst,
  input  logic                 step,
  output logic [ADDR_BITS-1:0] addr,
  output logic [ADDR_BITS-1:0] addr_next,
  output logic                 last
);

  logic [7:0] beat;
  logic [7:0] len;
  logic       fixed;

  // WRAP and reserved burst codes deliberately fall through to INCR behaviour
  assign addr_next = fixed ? addr : addr + ADDR_BITS'(1);
  assign last      = (beat == len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr  <= '0;
      beat  <= '0;
      len   <= '0;
      fixed <= 1'b0;
    end else if (load) begin
      addr  <= load_addr;
      beat  <= '0;
      len   <= load_len;
      fixed <= (load_burst == BURST_FIXED);
    end else if (step) begin
      addr  <= addr_next;
      beat  <= beat + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi_mm_mem_slave_if.sv
// ----------------------------------------------------------------------------
// axi_mm_mem_slave_if : AXI4 slave driving a dual-port BRAM with 1-cycle reads
// Revision            : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axi_mm_mem_slave_if
  import axi_mm_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int OPT_MEM_ADDR_BITS  = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic [1:0]                      s_axi_awburst,
  input  logic [2:0]                      s_axi_awsize,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_arid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  input  logic [1:0]                      s_axi_arburst,
  input  logic [2:0]                      s_axi_arsize,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_rid,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rlast,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic                            mem_wen,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] mem_wstrb,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   mem_wdata,
  output logic [OPT_MEM_ADDR_BITS-1:0]    mem_waddr,
  output logic                            mem_ren,
  output logic [OPT_MEM_ADDR_BITS-1:0]    mem_raddr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   mem_rdata
);

  localparam int ADDR_LSB = $clog2(C_S_AXI_DATA_WIDTH / 8);

  wr_state_t w_state, w_next;
  rd_state_t r_state, r_next;
  logic      active;
  logic      w_load, w_step, w_last;
  logic      r_load, r_step, r_last;
  logic [OPT_MEM_ADDR_BITS-1:0] w_addr, w_addr_next, r_addr, r_addr_next;
  logic      unused;

  assign unused = ^{s_axi_awsize, s_axi_arsize, s_axi_wlast, s_axi_awaddr, s_axi_araddr, w_addr_next};

  assign mem_wdata   = s_axi_wdata;
  assign mem_wstrb   = s_axi_wstrb;
  assign mem_waddr   = w_addr;
  assign s_axi_bresp = RESP_OKAY;
  assign s_axi_rresp = RESP_OKAY;
  assign s_axi_rdata = mem_rdata;

  axi_mm_burst_addr #(.ADDR_BITS(OPT_MEM_ADDR_BITS)) u_wr_addr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (w_load),
    .load_addr  (s_axi_awaddr[ADDR_LSB +: OPT_MEM_ADDR_BITS]),
    .load_len   (s_axi_awlen),
    .load_burst (s_axi_awburst),
    .step       (w_step),
    .addr       (w_addr),
    .addr_next  (w_addr_next),
    .last       (w_last)
  );

  axi_mm_burst_addr #(.ADDR_BITS(OPT_MEM_ADDR_BITS)) u_rd_addr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (r_load),
    .load_addr  (s_axi_araddr[ADDR_LSB +: OPT_MEM_ADDR_BITS]),
    .load_len   (s_axi_arlen),
    .load_burst (s_axi_arburst),
    .step       (r_step),
    .addr       (r_addr),
    .addr_next  (r_addr_next),
    .last       (r_last)
  );

  // Keeps the address-ready outputs low while reset is held and one cycle after
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= 1'b0;
      w_state   <= W_IDLE;
      r_state   <= R_IDLE;
      s_axi_bid <= '0;
      s_axi_rid <= '0;
    end else begin
      active  <= 1'b1;
      w_state <= w_next;
      r_state <= r_next;
      if (w_load) s_axi_bid <= s_axi_awid;
      if (r_load) s_axi_rid <= s_axi_arid;
    end
  end

  always_comb begin
    w_next        = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    mem_wen       = 1'b0;
    w_load        = 1'b0;
    w_step        = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi_awready = active;
        if (active && s_axi_awvalid) begin
          w_load = 1'b1;
          w_next = W_DATA;
        end
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          mem_wen = 1'b1;
          w_step  = 1'b1;
          if (w_last) w_next = W_RESP;
        end
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Next beat's read is issued on the handshake so data streams at one beat per cycle
  always_comb begin
    r_next        = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    mem_ren       = 1'b0;
    mem_raddr     = r_addr;
    r_load        = 1'b0;
    r_step        = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi_arready = active;
        if (active && s_axi_arvalid) begin
          r_load = 1'b1;
          r_next = R_ADDR;
        end
      end
      R_ADDR: begin
        mem_ren = 1'b1;
        r_next  = R_DATA;
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        s_axi_rlast  = r_last;
        if (s_axi_rready) begin
          if (r_last) begin
            r_next = R_IDLE;
          end else begin
            mem_ren   = 1'b1;
            mem_raddr = r_addr_next;
            r_step    = 1'b1;
          end
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

endmodule

`default_nettype wire
